// File: rtl/iir_biquad_cascade_pkg.sv
// Shared types and helpers for the biquad cascade: tap indices, FSM states,
// and the output clamp used after the Q-format shift.
package iir_pkg;
  localparam int NUM_TAPS = 5;
  localparam int K_B0 = 0;
  localparam int K_B1 = 1;
  localparam int K_B2 = 2;
  localparam int K_A1 = 3;
  localparam int K_A2 = 4;
  localparam int CLAMP_W = 64;

  typedef enum logic [1:0] {IDLE, MAC, SAT, DONE} state_e;

  // Clamp a (sign-extended) shifted accumulator into a dw-bit signed range.
  function automatic logic signed [CLAMP_W-1:0] sat_clamp(
    input logic signed [CLAMP_W-1:0] v, input int dw);
    logic signed [CLAMP_W-1:0] hi, lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/iir_biquad_cascade_if.sv
// Sample in/out handshakes, coefficient write port and status for the cascade.
interface iir_biquad_cascade_if #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 32,
  parameter int SECTIONS = 4
);
  localparam int AW = $clog2(SECTIONS * 5);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     state_clr;
  logic                     clear_sat;
  logic                     sat_flag;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
           state_clr, clear_sat,
    input  in_ready, out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
           state_clr, clear_sat,
    output in_ready, out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/iir_mac_sat.sv
// Shared multiplier-accumulator with the Q-format shift and output clamp.
module iir_mac_sat
  import iir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 32,
  parameter int FRAC   = 15,
  parameter int ACC_W  = DATA_W + COEF_W + 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic                     i_sub,
  input  logic signed [COEF_W-1:0] i_coef,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_y,
  output logic                     o_sat
);
  logic signed [DATA_W+COEF_W-1:0] w_prod;
  logic signed [ACC_W-1:0]         w_prod_ext;
  logic signed [ACC_W-1:0]         r_acc;
  logic signed [ACC_W-1:0]         w_shift;
  logic signed [CLAMP_W-1:0]       w_shift_ext;
  logic signed [CLAMP_W-1:0]       w_clamp;

  assign w_prod     = i_coef * i_data;
  assign w_prod_ext = ACC_W'(w_prod);

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_acc <= '0;
    else if (i_en)
      r_acc <= i_sub ? r_acc - w_prod_ext : r_acc + w_prod_ext;
  end

  // Arithmetic shift floors toward -inf, so small negative tails settle at -1.
  assign w_shift     = r_acc >>> FRAC;
  assign w_shift_ext = CLAMP_W'(w_shift);
  assign w_clamp     = sat_clamp(w_shift_ext, DATA_W);
  assign o_y         = DATA_W'(w_clamp);
  assign o_sat       = (w_clamp != w_shift_ext);
endmodule

// File: rtl/iir_biquad_cascade.sv
// Cascade of direct-form-I biquads time-multiplexed onto one MAC; control FSM,
// coefficient file and per-section delay lines live here.
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 32,
  parameter int FRAC     = 15,
  parameter int SECTIONS = 4,
  localparam int ACC_W   = DATA_W + COEF_W + 3
) (
  input logic               clk,
  input logic               rst,
  iir_biquad_cascade_if.slave bus
);
  localparam int NCOEF = SECTIONS * NUM_TAPS;
  localparam int AW    = $clog2(NCOEF);
  localparam int SW    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1) <<< FRAC;

  state_e                   r_state, w_next;
  logic [SW-1:0]            r_sec;
  logic [2:0]               r_tap;
  logic signed [COEF_W-1:0] r_coef [NCOEF];
  logic signed [DATA_W-1:0] r_x;
  logic signed [DATA_W-1:0] r_x1 [SECTIONS];
  logic signed [DATA_W-1:0] r_x2 [SECTIONS];
  logic signed [DATA_W-1:0] r_y1 [SECTIONS];
  logic signed [DATA_W-1:0] r_y2 [SECTIONS];
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_out_valid;
  logic                     r_sat;

  logic                     w_in_ready, w_accept, w_mac_en, w_acc_clr, w_sub;
  logic                     w_last_sec, w_sat;
  logic [AW-1:0]            w_cidx;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [DATA_W-1:0] w_data, w_y;

  assign w_last_sec = (r_sec == SW'(SECTIONS - 1));
  assign w_accept   = w_in_ready & bus.in_valid;
  assign w_sub      = (r_tap >= 3'(K_A1));
  assign w_cidx     = AW'(int'(r_sec) * NUM_TAPS + int'(r_tap));
  assign w_coef     = r_coef[w_cidx];

  always_comb begin
    w_data = r_x;
    case (r_tap)
      3'(K_B1): w_data = r_x1[r_sec];
      3'(K_B2): w_data = r_x2[r_sec];
      3'(K_A1): w_data = r_y1[r_sec];
      3'(K_A2): w_data = r_y2[r_sec];
      default:  w_data = r_x;
    endcase
  end

  iir_mac_sat #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC(FRAC), .ACC_W(ACC_W)
  ) u_mac (
    .clk(clk), .rst(rst), .i_clr(w_acc_clr), .i_en(w_mac_en), .i_sub(w_sub),
    .i_coef(w_coef), .i_data(w_data), .o_y(w_y), .o_sat(w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = MAC;
      MAC:     if (r_tap == 3'(NUM_TAPS - 1)) w_next = SAT;
      SAT:     w_next = w_last_sec ? DONE : MAC;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state_clr wins over a same-cycle sample, so it masks in_ready.
  always_comb begin
    w_in_ready = 1'b0;
    w_mac_en   = 1'b0;
    w_acc_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = ~bus.state_clr;
        w_acc_clr  = 1'b1;
      end
      MAC:     w_mac_en  = 1'b1;
      SAT:     w_acc_clr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec       <= '0;
      r_tap       <= '0;
      r_x         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      for (int i = 0; i < NCOEF; i++)
        r_coef[i] <= ((i % NUM_TAPS) == K_B0) ? COEF_ONE : '0;
      for (int s = 0; s < SECTIONS; s++) begin
        r_x1[s] <= '0;
        r_x2[s] <= '0;
        r_y1[s] <= '0;
        r_y2[s] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.state_clr)
            for (int s = 0; s < SECTIONS; s++) begin
              r_x1[s] <= '0;
              r_x2[s] <= '0;
              r_y1[s] <= '0;
              r_y2[s] <= '0;
            end
          if (bus.coef_we && (bus.coef_addr < AW'(NCOEF)))
            r_coef[bus.coef_addr] <= bus.coef_wdata;
          if (w_accept) begin
            r_x   <= bus.in_data;
            r_sec <= '0;
            r_tap <= '0;
          end
        end
        MAC: r_tap <= r_tap + 3'd1;
        SAT: begin
          // The clamped value feeds both the feedback line and the next section.
          r_x1[r_sec] <= r_x;
          r_x2[r_sec] <= r_x1[r_sec];
          r_y1[r_sec] <= w_y;
          r_y2[r_sec] <= r_y1[r_sec];
          r_x         <= w_y;
          r_tap       <= '0;
          if (w_last_sec) begin
            r_out_data  <= w_y;
            r_out_valid <= 1'b1;
          end else begin
            r_sec <= r_sec + SW'(1);
          end
        end
        DONE: if (bus.out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase

      if (r_state == SAT && w_sat) r_sat <= 1'b1;
      else if (bus.clear_sat)      r_sat <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready & ~rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.sat_flag  = r_sat;
endmodule
